// File: rtl/usb_gpx_event_ctrl_if.sv
// Avalon-MM slave bus plus interrupt line of the USB GPX event controller.
interface usb_gpx_event_ctrl_if;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        irq;

  modport master (
    output address, chipselect, write_n, writedata,
    input  readdata, irq
  );

  modport slave (
    input  address, chipselect, write_n, writedata,
    output readdata, irq
  );
endinterface

// File: rtl/usb_gpx_event_ctrl.sv
// USB GPX pin event controller: 2-flop sync, glitch filter, edge events, PEND/COUNT, irq.
// Optional feature: define USB_GPX_TIMESTAMP_EN for an event timestamp at address 4.
module usb_gpx_event_ctrl #(
  parameter int unsigned FILTER_CYCLES = 4
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 in_port,
  usb_gpx_event_ctrl_if.slave  bus
);

  localparam logic [2:0] ADDR_DATA   = 3'd0;
  localparam logic [2:0] ADDR_CTRL   = 3'd1;
  localparam logic [2:0] ADDR_PEND   = 3'd2;
  localparam logic [2:0] ADDR_COUNT  = 3'd3;
  localparam logic [2:0] ADDR_TSTAMP = 3'd4;
  localparam logic [7:0] FILTER_LAST = 8'(FILTER_CYCLES - 1);

  logic        sync1_reg;
  logic        sync2_reg;
  logic        filt_reg;
  logic [7:0]  filt_cnt_reg;
  logic        filt_toggle;
  logic        event_hit;

  logic        ctrl_ien_reg;
  logic        ctrl_fall_reg;
  logic        ctrl_both_reg;
  logic        pend_reg;
  logic [15:0] count_reg;
  logic        irq_reg;
  logic [31:0] readdata_reg;
  logic [31:0] rdata_next;
  logic [31:0] ts_rdata;

  logic        wr_en;
  logic        wr_ctrl;
  logic        wr_pend;
  logic        wr_count;
  logic        wdata_unused;

  // in_port is asynchronous: nothing looks at it except the first flop
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_reg <= 1'b0;
      sync2_reg <= 1'b0;
    end else begin
      sync1_reg <= in_port;
      sync2_reg <= sync1_reg;
    end
  end

  assign filt_toggle = (sync2_reg != filt_reg) && (filt_cnt_reg == FILTER_LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      filt_reg     <= 1'b0;
      filt_cnt_reg <= 8'd0;
    end else if (sync2_reg == filt_reg) begin
      filt_cnt_reg <= 8'd0;
    end else if (filt_cnt_reg == FILTER_LAST) begin
      filt_reg     <= ~filt_reg;
      filt_cnt_reg <= 8'd0;
    end else begin
      filt_cnt_reg <= filt_cnt_reg + 8'd1;
    end
  end

  // filt_reg still holds the old level here, so filt_reg=1 means a 1->0 transition
  assign event_hit = filt_toggle &&
                     (ctrl_both_reg || (ctrl_fall_reg ? filt_reg : ~filt_reg));

  assign wr_en        = bus.chipselect && !bus.write_n;
  assign wr_ctrl      = wr_en && (bus.address == ADDR_CTRL);
  assign wr_pend      = wr_en && (bus.address == ADDR_PEND);
  assign wr_count     = wr_en && (bus.address == ADDR_COUNT);
  assign wdata_unused = ^bus.writedata[31:3];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ctrl_ien_reg  <= 1'b0;
      ctrl_fall_reg <= 1'b0;
      ctrl_both_reg <= 1'b0;
    end else if (wr_ctrl) begin
      ctrl_ien_reg  <= bus.writedata[0];
      ctrl_fall_reg <= bus.writedata[1];
      ctrl_both_reg <= bus.writedata[2];
    end
  end

  // an event in the same cycle as a software clear always wins
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pend_reg <= 1'b0;
    end else if (event_hit) begin
      pend_reg <= 1'b1;
    end else if (wr_pend && bus.writedata[0]) begin
      pend_reg <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_reg <= 16'd0;
    end else if (wr_count) begin
      count_reg <= event_hit ? 16'd1 : 16'd0;
    end else if (event_hit && (count_reg != 16'hFFFF)) begin
      count_reg <= count_reg + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irq_reg <= 1'b0;
    end else begin
      irq_reg <= pend_reg & ctrl_ien_reg;
    end
  end

`ifdef USB_GPX_TIMESTAMP_EN
  logic [31:0] ts_cnt_reg;
  logic [31:0] ts_latch_reg;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ts_cnt_reg   <= 32'd0;
      ts_latch_reg <= 32'd0;
    end else begin
      ts_cnt_reg <= ts_cnt_reg + 32'd1;
      if (event_hit) begin
        ts_latch_reg <= ts_cnt_reg;
      end
    end
  end

  assign ts_rdata = ts_latch_reg;
`else
  assign ts_rdata = 32'd0;
`endif

  always_comb begin
    rdata_next = 32'd0;
    case (bus.address)
      ADDR_DATA:   rdata_next = {31'd0, filt_reg};
      ADDR_CTRL:   rdata_next = {29'd0, ctrl_both_reg, ctrl_fall_reg, ctrl_ien_reg};
      ADDR_PEND:   rdata_next = {31'd0, pend_reg};
      ADDR_COUNT:  rdata_next = {16'd0, count_reg};
      ADDR_TSTAMP: rdata_next = ts_rdata;
      default:     rdata_next = 32'd0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      readdata_reg <= 32'd0;
    end else begin
      readdata_reg <= rdata_next;
    end
  end

  assign bus.readdata = readdata_reg;
  assign bus.irq      = irq_reg;

endmodule
